// File: rtl/display_sequencer_pkg.sv
// Shared definitions for the seven-segment display sequencer: glyph codes,
// display modes, message identifiers and the message glyph ROM.
package display_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_IDLE = 2'd0,
        MODE_NUM  = 2'd1,
        MODE_MSG  = 2'd2
    } mode_e;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    localparam logic [6:0] GLYPH_0 = 7'b1000000;
    localparam logic [6:0] GLYPH_1 = 7'b1111001;
    localparam logic [6:0] GLYPH_2 = 7'b0100100;
    localparam logic [6:0] GLYPH_3 = 7'b0110000;
    localparam logic [6:0] GLYPH_4 = 7'b0011001;
    localparam logic [6:0] GLYPH_5 = 7'b0010010;
    localparam logic [6:0] GLYPH_6 = 7'b0000010;
    localparam logic [6:0] GLYPH_7 = 7'b1111000;
    localparam logic [6:0] GLYPH_8 = 7'b0000000;
    localparam logic [6:0] GLYPH_9 = 7'b0011000;

    localparam logic [6:0] GLYPH_E = 7'b0000110;
    localparam logic [6:0] GLYPH_A = 7'b0001000;
    localparam logic [6:0] GLYPH_S = 7'b0010010;
    localparam logic [6:0] GLYPH_Y = 7'b0010001;
    localparam logic [6:0] GLYPH_H = 7'b0001001;
    localparam logic [6:0] GLYPH_R = 7'b0101111;
    localparam logic [6:0] GLYPH_D = 7'b0100001;
    localparam logic [6:0] GLYPH_U = 7'b1000001;
    localparam logic [6:0] GLYPH_G = 7'b1000010;
    localparam logic [6:0] GLYPH_O = 7'b1000000;
    localparam logic [6:0] GLYPH_N = 7'b0101011;

    // Message identifiers
    localparam logic [2:0] MSG_EASY = 3'd0;
    localparam logic [2:0] MSG_HARD = 3'd1;
    localparam logic [2:0] MSG_RUSH = 3'd2;
    localparam logic [2:0] MSG_ERR  = 3'd3;
    localparam logic [2:0] MSG_GO   = 3'd4;
    localparam logic [2:0] MSG_DONE = 3'd5;

    // Largest value the four-digit panel can show
    localparam logic [13:0] NUM_MAX = 14'd9999;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        logic [6:0] g;
        case (d)
            4'd0:    g = GLYPH_0;
            4'd1:    g = GLYPH_1;
            4'd2:    g = GLYPH_2;
            4'd3:    g = GLYPH_3;
            4'd4:    g = GLYPH_4;
            4'd5:    g = GLYPH_5;
            4'd6:    g = GLYPH_6;
            4'd7:    g = GLYPH_7;
            4'd8:    g = GLYPH_8;
            4'd9:    g = GLYPH_9;
            default: g = GLYPH_BLANK;
        endcase
        return g;
    endfunction

    // Message ROM: four glyphs per message, slot 0 is the leftmost digit
    function automatic logic [6:0] msg_glyph(input logic [2:0] id, input logic [1:0] slot);
        logic [27:0] row;
        logic [6:0]  g;
        case (id)
            MSG_EASY: row = {GLYPH_E, GLYPH_A, GLYPH_S, GLYPH_Y};
            MSG_HARD: row = {GLYPH_H, GLYPH_A, GLYPH_R, GLYPH_D};
            MSG_RUSH: row = {GLYPH_R, GLYPH_U, GLYPH_S, GLYPH_H};
            MSG_ERR:  row = {GLYPH_E, GLYPH_R, GLYPH_R, GLYPH_BLANK};
            MSG_GO:   row = {GLYPH_BLANK, GLYPH_BLANK, GLYPH_G, GLYPH_O};
            MSG_DONE: row = {GLYPH_D, GLYPH_O, GLYPH_N, GLYPH_E};
            default:  row = {4{GLYPH_BLANK}};
        endcase
        case (slot)
            2'd0:    g = row[27:21];
            2'd1:    g = row[20:14];
            2'd2:    g = row[13:7];
            default: g = row[6:0];
        endcase
        return g;
    endfunction

endpackage

// File: rtl/display_sequencer_bin2bcd.sv
// Sequential double-dabble converter: 14-bit binary to four BCD digits,
// one bit per cycle. A start while busy discards the running conversion.
module bin2bcd_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [13:0] bin,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd
);

    localparam logic [3:0] LAST_STEP = 4'd13;

    // {bcd[15:0], bin[13:0]} working register
    logic [29:0] sr_q, sr_d;
    logic [29:0] shifted;
    logic [3:0]  cnt_q;
    logic        busy_q;
    logic        done_q;

    // Shift first, then correct digits for the next shift; the final step
    // skips the correction. Same result as adjust-then-shift since the
    // first adjust always sees zero digits.
    always_comb begin
        shifted = {sr_q[28:0], 1'b0};
        sr_d    = shifted;
        if (cnt_q != LAST_STEP) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (shifted[14 + 4*i +: 4] >= 4'd5)
                    sr_d[14 + 4*i +: 4] = shifted[14 + 4*i +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then 14 shift steps and a one-cycle done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                sr_q   <= {16'd0, bin};
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                sr_q <= sr_d;
                if (cnt_q == LAST_STEP) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 4'd1;
                end
            end
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = sr_q[29:14];

endmodule

// File: rtl/display_sequencer.sv
// Four-digit seven-segment display controller: arbitrates timed messages
// against the number path, blinks numbers on request and scans the panel.
module display_sequencer
    import display_sequencer_pkg::*;
#(
    parameter int unsigned MSG_TICKS = 10,
    parameter int unsigned LZB       = 1
) (
    input  logic        clk_500Hz,
    input  logic        rst,
    input  logic        tick_5Hz,
    input  logic        msg_req,
    input  logic [2:0]  msg_id,
    input  logic        num_req,
    input  logic [13:0] number,
    input  logic        blink_en,
    output logic [6:0]  seg,
    output logic [3:0]  an,
    output logic        busy
);

    localparam int unsigned HOLD_W = (MSG_TICKS > 1) ? $clog2(MSG_TICKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MSG_TICKS - 1);

    mode_e             mode_q;
    logic [2:0]        msg_id_q;
    logic [HOLD_W-1:0] hold_q;
    logic              busy_q;
    logic [15:0]       num_bcd_q;
    logic              num_valid_q;
    logic              blink_q;
    logic [1:0]        slot_q;
    logic [6:0]        seg_q, seg_d;
    logic [3:0]        an_q, an_d;

    logic [13:0]       conv_bin;
    logic              conv_busy;
    logic              conv_done;
    logic              conv_ok;
    logic [15:0]       conv_bcd;

    assign conv_bin = (number > NUM_MAX) ? NUM_MAX : number;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk_500Hz),
        .rst   (rst),
        .start (num_req),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Only a finished, not-yet-restarted conversion publishes its digits
    assign conv_ok = conv_done && !conv_busy;

    // Mode FSM with message hold counter, busy flag and latched number
    always_ff @(posedge clk_500Hz or posedge rst) begin
        if (rst) begin
            mode_q      <= MODE_IDLE;
            msg_id_q    <= '0;
            hold_q      <= '0;
            busy_q      <= 1'b0;
            num_bcd_q   <= '0;
            num_valid_q <= 1'b0;
        end else begin
            if (conv_ok) begin
                num_bcd_q   <= conv_bcd;
                num_valid_q <= 1'b1;
            end
            if (msg_req) begin
                mode_q   <= MODE_MSG;
                msg_id_q <= msg_id;
                hold_q   <= '0;
                busy_q   <= 1'b1;
            end else begin
                case (mode_q)
                    MODE_IDLE: begin
                        if (conv_ok)
                            mode_q <= MODE_NUM;
                    end
                    MODE_MSG: begin
                        if (tick_5Hz) begin
                            if (hold_q == HOLD_LAST) begin
                                hold_q <= '0;
                                busy_q <= 1'b0;
                                mode_q <= (num_valid_q || conv_ok) ? MODE_NUM : MODE_IDLE;
                            end else begin
                                hold_q <= hold_q + 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Blink phase: toggles per tick while enabled, held at 0 otherwise
    always_ff @(posedge clk_500Hz or posedge rst) begin
        if (rst)
            blink_q <= 1'b0;
        else if (!blink_en)
            blink_q <= 1'b0;
        else if (tick_5Hz)
            blink_q <= ~blink_q;
    end

    // Glyph selection for the current scan slot, with leading-zero blanking
    always_comb begin
        logic [3:0] digit;
        logic       lead_zero;
        logic       z3, z2, z1;
        logic       dark;
        logic [6:0] glyph;

        z3 = (num_bcd_q[15:12] == 4'd0);
        z2 = z3 && (num_bcd_q[11:8] == 4'd0);
        z1 = z2 && (num_bcd_q[7:4] == 4'd0);

        digit     = 4'd0;
        lead_zero = 1'b0;
        case (slot_q)
            2'd0: begin digit = num_bcd_q[15:12]; lead_zero = z3;   end
            2'd1: begin digit = num_bcd_q[11:8];  lead_zero = z2;   end
            2'd2: begin digit = num_bcd_q[7:4];   lead_zero = z1;   end
            default: begin digit = num_bcd_q[3:0]; lead_zero = 1'b0; end
        endcase

        case (mode_q)
            MODE_NUM: glyph = ((LZB != 0) && lead_zero) ? GLYPH_BLANK : digit_glyph(digit);
            MODE_MSG: glyph = msg_glyph(msg_id_q, slot_q);
            default:  glyph = GLYPH_BLANK;
        endcase

        dark  = (mode_q == MODE_NUM) && blink_en && blink_q;
        seg_d = dark ? GLYPH_BLANK : glyph;
        an_d  = (dark || glyph == GLYPH_BLANK) ? 4'b1111 : ~(4'b0001 << slot_q);
    end

    // Scan slot counter and registered panel drive
    always_ff @(posedge clk_500Hz or posedge rst) begin
        if (rst) begin
            slot_q <= '0;
            seg_q  <= '1;
            an_q   <= '1;
        end else begin
            slot_q <= slot_q + 2'd1;
            seg_q  <= seg_d;
            an_q   <= an_d;
        end
    end

    assign seg  = seg_q;
    assign an   = an_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Directed bench for display_sequencer: number table, conversion latency,
// abort, message hold/restart, blink and reset-abort sequences.
module tb_display_sequencer;

    logic        clk_500Hz = 1'b0;
    logic        rst       = 1'b1;
    logic        tick_5Hz  = 1'b0;
    logic        msg_req   = 1'b0;
    logic [2:0]  msg_id    = 3'd0;
    logic        num_req   = 1'b0;
    logic [13:0] number    = 14'd0;
    logic        blink_en  = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic        busy;

    int checks = 0;
    int errors = 0;

    localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                           G3 = 7'b0110000, G4 = 7'b0011001, G5 = 7'b0010010,
                           G7 = 7'b1111000, G9 = 7'b0011000;
    localparam logic [6:0] LE = 7'b0000110, LA = 7'b0001000, LS = 7'b0010010,
                           LY = 7'b0010001, LH = 7'b0001001, LR = 7'b0101111,
                           LD = 7'b0100001, LU = 7'b1000001, LG = 7'b1000010,
                           LO = 7'b1000000, LN = 7'b0101011, GB = 7'b1111111;

    display_sequencer #(.MSG_TICKS(10), .LZB(1)) dut (
        .clk_500Hz (clk_500Hz),
        .rst       (rst),
        .tick_5Hz  (tick_5Hz),
        .msg_req   (msg_req),
        .msg_id    (msg_id),
        .num_req   (num_req),
        .number    (number),
        .blink_en  (blink_en),
        .seg       (seg),
        .an        (an),
        .busy      (busy)
    );

    always #5 clk_500Hz = ~clk_500Hz;

    // Clock edges since reset release: the glyph on the pins belongs to slot (edges-1) mod 4
    int unsigned edges;
    always @(posedge clk_500Hz or posedge rst) begin
        if (rst) edges <= 0;
        else     edges <= edges + 1;
    end

    typedef struct {
        logic [13:0] num;
        logic [27:0] exp;
    } vec_t;
    vec_t vecs[8];

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Samples four consecutive cycles; exp = {slot0,slot1,slot2,slot3} glyphs
    task automatic check_panel(input string nm, input logic [27:0] exp);
        int unsigned k;
        int          base;
        logic [6:0]  eseg;
        logic [3:0]  ean;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk_500Hz);
            k    = (edges + 3) % 4;
            base = 27 - 7 * int'(k);
            eseg = exp[base -: 7];
            ean  = (eseg == GB) ? 4'b1111 : ~(4'b0001 << k);
            checks++;
            if (seg !== eseg || an !== ean) begin
                errors++;
                $display("FAIL %s slot%0d: seg=%b an=%b, expected seg=%b an=%b",
                         nm, k, seg, an, eseg, ean);
            end
        end
    endtask

    task automatic check_dark(input string nm);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk_500Hz);
            check_val(nm, {28'd0, an}, 32'hF);
        end
    endtask

    task automatic send_num(input logic [13:0] v);
        @(negedge clk_500Hz);
        num_req = 1'b1;
        number  = v;
        @(negedge clk_500Hz);
        num_req = 1'b0;
    endtask

    task automatic send_msg(input logic [2:0] id, input bit with_tick);
        @(negedge clk_500Hz);
        msg_req  = 1'b1;
        msg_id   = id;
        tick_5Hz = with_tick;
        @(negedge clk_500Hz);
        msg_req  = 1'b0;
        tick_5Hz = 1'b0;
    endtask

    task automatic send_both(input logic [2:0] id, input logic [13:0] v);
        @(negedge clk_500Hz);
        msg_req = 1'b1;
        msg_id  = id;
        num_req = 1'b1;
        number  = v;
        @(negedge clk_500Hz);
        msg_req = 1'b0;
        num_req = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk_500Hz);
        tick_5Hz = 1'b1;
        @(negedge clk_500Hz);
        tick_5Hz = 1'b0;
    endtask

    // n ticks, checking busy after each; if exits, busy must drop on the last one
    task automatic hold_ticks(input string nm, input int n, input bit exits);
        for (int i = 0; i < n; i++) begin
            tick();
            check_val(nm, {31'd0, busy}, (exits && i == n - 1) ? 32'd0 : 32'd1);
        end
    endtask

    task automatic pulse_rst(input string nm);
        @(negedge clk_500Hz);
        rst = 1'b1;
        #1;
        check_val({nm, " seg"}, {25'd0, seg}, 32'h7F);
        check_val({nm, " an"}, {28'd0, an}, 32'hF);
        check_val({nm, " busy"}, {31'd0, busy}, 32'd0);
        @(negedge clk_500Hz);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{14'd1234,  {G1, G2, G3, G4}};
        vecs[1] = '{14'd7,     {GB, GB, GB, G7}};
        vecs[2] = '{14'd0,     {GB, GB, GB, G0}};
        vecs[3] = '{14'd12000, {G9, G9, G9, G9}};
        vecs[4] = '{14'd1005,  {G1, G0, G0, G5}};
        vecs[5] = '{14'd50,    {GB, GB, G5, G0}};
        vecs[6] = '{14'd300,   {GB, G3, G0, G0}};
        vecs[7] = '{14'd16383, {G9, G9, G9, G9}};

        // Reset state
        repeat (3) @(negedge clk_500Hz);
        check_val("reset seg", {25'd0, seg}, 32'h7F);
        check_val("reset an", {28'd0, an}, 32'hF);
        check_val("reset busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk_500Hz);
        check_panel("idle blank", {4{GB}});

        // Number table
        foreach (vecs[i]) begin
            send_num(vecs[i].num);
            repeat (20) @(negedge clk_500Hz);
            check_panel($sformatf("num %0d", vecs[i].num), vecs[i].exp);
            check_val("num busy", {31'd0, busy}, 32'd0);
        end

        // Conversion latency: old digits through cycle 15, new from cycle 16
        send_num(14'd1234);
        repeat (8) @(negedge clk_500Hz);
        check_panel("latency old", {G9, G9, G9, G9});
        repeat (3) @(negedge clk_500Hz);
        check_panel("latency new", {G1, G2, G3, G4});

        // Restart mid-conversion: 1111 never shows, 2222 lands 15 cycles after restart
        send_num(14'd1111);
        repeat (4) @(negedge clk_500Hz);
        send_num(14'd2222);
        repeat (10) @(negedge clk_500Hz);
        check_panel("abort old", {G1, G2, G3, G4});
        @(negedge clk_500Hz);
        check_panel("abort new", {G2, G2, G2, G2});

        // Message over a number, returns to the number
        send_msg(3'd1, 1'b0);
        check_val("msg busy rise", {31'd0, busy}, 32'd1);
        check_panel("HArd", {LH, LA, LR, LD});
        hold_ticks("HArd hold", 10, 1'b1);
        check_panel("after HArd", {G2, G2, G2, G2});

        // num_req during MSG, then message restart with a coincident tick
        send_msg(3'd2, 1'b0);
        send_num(14'd42);
        repeat (20) @(negedge clk_500Hz);
        check_panel("rUSH held", {LR, LU, LS, LH});
        hold_ticks("rUSH hold", 5, 1'b0);
        send_msg(3'd5, 1'b1);
        check_panel("dOnE", {LD, LO, LN, LE});
        hold_ticks("dOnE hold", 10, 1'b1);
        check_panel("after dOnE", {GB, GB, G4, G2});

        // Blink: dark on alternate tick periods, lit as soon as disabled
        @(negedge clk_500Hz);
        blink_en = 1'b1;
        check_panel("blink phase0", {GB, GB, G4, G2});
        tick();
        @(negedge clk_500Hz);
        check_dark("blink dark1");
        tick();
        @(negedge clk_500Hz);
        check_panel("blink lit", {GB, GB, G4, G2});
        tick();
        @(negedge clk_500Hz);
        check_dark("blink dark2");
        blink_en = 1'b0;
        check_panel("blink off", {GB, GB, G4, G2});

        // Reset mid-conversion discards it
        send_num(14'd5555);
        repeat (5) @(negedge clk_500Hz);
        pulse_rst("rst conv");
        repeat (25) @(negedge clk_500Hz);
        check_panel("after rst conv", {4{GB}});

        // Message with no valid number falls back to blank
        send_msg(3'd4, 1'b0);
        check_panel("GO", {GB, GB, LG, LO});
        hold_ticks("GO hold", 10, 1'b1);
        check_panel("after GO", {4{GB}});

        // msg_req and num_req together: conversion runs under the message
        send_both(3'd3, 14'd77);
        check_panel("Err", {LE, LR, LR, GB});
        hold_ticks("Err hold", 10, 1'b1);
        check_panel("after Err", {GB, GB, G7, G7});

        // Reset mid-message discards message and number
        send_msg(3'd0, 1'b0);
        check_panel("EASY", {LE, LA, LS, LY});
        pulse_rst("rst msg");
        repeat (25) @(negedge clk_500Hz);
        check_panel("after rst msg", {4{GB}});
        check_val("after rst busy", {31'd0, busy}, 32'd0);
        send_num(14'd1234);
        repeat (20) @(negedge clk_500Hz);
        check_panel("num after rst", {G1, G2, G3, G4});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
